// File: rtl/mem_access_ctrl.sv
// Load/store memory access controller: IDLE/ACCESS/RESP handshake with timeout, lane extraction and byte enables.
// Optional feature: define LOAD_SIGN_EXT_EN to honour req_signed on byte/halfword loads.
module mem_access_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  output logic        stall,
  output logic [31:0] load_data,
  output logic        load_valid,
  output logic        misaligned,
  output logic        timeout_err,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack
);

  typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, RESP = 2'd2} state_t;

  localparam logic [7:0] LAST_WAIT = 8'(TIMEOUT_CYCLES - 1);

  state_t      state_r;
  logic [7:0]  wait_cnt_r;
  logic [1:0]  lane_r;
  logic [1:0]  size_r;
  logic        write_r;
  logic        aligned_s;
  logic        sign_s;
  logic [7:0]  byte_s;
  logic [15:0] half_s;
  logic [31:0] load_ext_s;
  logic [3:0]  store_be_s;
  logic [31:0] store_data_s;

`ifdef LOAD_SIGN_EXT_EN
  logic signed_r;
  assign sign_s = signed_r;
`else
  logic unused_s;
  assign unused_s = req_signed;
  assign sign_s   = 1'b0;
`endif

  // Alignment check and store lane steering for the incoming request
  always_comb begin
    aligned_s    = 1'b0;
    store_be_s   = 4'b1111;
    store_data_s = req_wdata;
    case (req_size)
      2'd1: begin
        aligned_s    = (req_addr[0] == 1'b0);
        store_be_s   = req_addr[1] ? 4'b1100 : 4'b0011;
        store_data_s = {2{req_wdata[15:0]}};
      end
      2'd2: begin
        aligned_s    = 1'b1;
        store_be_s   = 4'b0001 << req_addr[1:0];
        store_data_s = {4{req_wdata[7:0]}};
      end
      default: begin
        aligned_s    = (req_addr[1:0] == 2'b00);
        store_be_s   = 4'b1111;
        store_data_s = req_wdata;
      end
    endcase
  end

  // Load lane extraction from the returned word, using the latched request
  always_comb begin
    byte_s = mem_rdata[{lane_r, 3'b000} +: 8];
    half_s = mem_rdata[{lane_r[1], 4'b0000} +: 16];
    case (size_r)
      2'd2:    load_ext_s = {{24{sign_s & byte_s[7]}}, byte_s};
      2'd1:    load_ext_s = {{16{sign_s & half_s[15]}}, half_s};
      default: load_ext_s = mem_rdata;
    endcase
  end

  // Held low during reset so the pipeline is never frozen by a stale request
  assign stall = ~reset & (((state_r == IDLE) & req_valid & aligned_s) | (state_r == ACCESS));

  // Controller FSM with all memory-side and status outputs registered
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r     <= IDLE;
      wait_cnt_r  <= 8'd0;
      lane_r      <= 2'd0;
      size_r      <= 2'd0;
      write_r     <= 1'b0;
`ifdef LOAD_SIGN_EXT_EN
      signed_r    <= 1'b0;
`endif
      load_data   <= 32'd0;
      load_valid  <= 1'b0;
      misaligned  <= 1'b0;
      timeout_err <= 1'b0;
      mem_req     <= 1'b0;
      mem_we      <= 1'b0;
      mem_addr    <= 32'd0;
      mem_wdata   <= 32'd0;
      mem_be      <= 4'd0;
    end else begin
      load_valid  <= 1'b0;
      misaligned  <= 1'b0;
      timeout_err <= 1'b0;
      case (state_r)
        IDLE: begin
          if (req_valid && aligned_s) begin
            state_r    <= ACCESS;
            wait_cnt_r <= 8'd0;
            lane_r     <= req_addr[1:0];
            size_r     <= req_size;
            write_r    <= req_write;
`ifdef LOAD_SIGN_EXT_EN
            signed_r   <= req_signed;
`endif
            mem_req    <= 1'b1;
            mem_we     <= req_write;
            mem_addr   <= {req_addr[31:2], 2'b00};
            mem_wdata  <= req_write ? store_data_s : 32'd0;
            mem_be     <= req_write ? store_be_s : 4'b1111;
          end else if (req_valid) begin
            misaligned <= 1'b1;
          end else begin
            state_r <= IDLE;
          end
        end
        ACCESS: begin
          // An ack arriving on the final allowed cycle still completes the access
          if (mem_ack) begin
            state_r <= RESP;
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
            if (!write_r) begin
              load_data  <= load_ext_s;
              load_valid <= 1'b1;
            end else begin
              load_valid <= 1'b0;
            end
          end else if (wait_cnt_r == LAST_WAIT) begin
            state_r     <= IDLE;
            mem_req     <= 1'b0;
            mem_we      <= 1'b0;
            timeout_err <= 1'b1;
          end else begin
            wait_cnt_r <= wait_cnt_r + 8'd1;
          end
        end
        RESP:    state_r <= IDLE;
        default: state_r <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Randomized self-checking bench for mem_access_ctrl against a transaction-level reference model.
module tb_mem_access_ctrl;
  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_write, req_signed;
  logic [31:0] req_addr, req_wdata;
  logic [1:0]  req_size;
  logic        stall, load_valid, misaligned, timeout_err;
  logic [31:0] load_data;
  logic        mem_req, mem_we, mem_ack;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_be;

  int checks = 0;
  int errors = 0;

  mem_access_ctrl #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_size(req_size), .req_signed(req_signed),
    .stall(stall), .load_data(load_data), .load_valid(load_valid), .misaligned(misaligned),
    .timeout_err(timeout_err), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_be(mem_be), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic model_aligned(input logic [1:0] sz, input logic [31:0] a);
    if (sz == 2'd2) return 1'b1;
    if (sz == 2'd1) return (a % 2) == 0;
    return (a % 4) == 0;
  endfunction

  function automatic logic [3:0] model_be(input logic [1:0] sz, input logic [31:0] a);
    if (sz == 2'd2) return 4'(1 << (a % 4));
    if (sz == 2'd1) return 4'(3 << (a & 2));
    return 4'hF;
  endfunction

  function automatic logic [31:0] model_wdata(input logic [1:0] sz, input logic [31:0] d);
    if (sz == 2'd2) return (d & 32'hFF) * 32'h0101_0101;
    if (sz == 2'd1) return (d & 32'hFFFF) * 32'h0001_0001;
    return d;
  endfunction

  function automatic logic [31:0] model_load(input logic [1:0] sz, input logic [31:0] a,
                                             input logic [31:0] rd, input logic sg);
    logic [31:0] v;
    if (sz == 2'd2) begin
      v = (rd >> ((a % 4) * 8)) & 32'hFF;
`ifdef LOAD_SIGN_EXT_EN
      if (sg && v >= 32'h80) v = v + 32'hFFFF_FF00;
`endif
    end else if (sz == 2'd1) begin
      v = (rd >> ((a & 2) * 8)) & 32'hFFFF;
`ifdef LOAD_SIGN_EXT_EN
      if (sg && v >= 32'h8000) v = v + 32'hFFFF_0000;
`endif
    end else begin
      v = rd;
    end
    if (sg === 1'bx) v = 32'hx;
    return v;
  endfunction

  // One request from issue to completion; delay >= TO means ack is never given
  task automatic run_txn(input logic w, input logic [31:0] a, input logic [31:0] wd,
                         input logic [1:0] sz, input logic sg, input int delay, input logic [31:0] rd);
    logic al;
    bit acked;
    al = model_aligned(sz, a);
    @(negedge clk);
    req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = wd; req_size = sz; req_signed = sg;
    #1 check_eq("stall_on_accept", stall, al);
    @(negedge clk);
    req_valid = 1'b0; req_addr = $urandom; req_wdata = $urandom; req_size = 2'($urandom);
    if (!al) begin
      check_eq("misaligned_pulse", misaligned, 1'b1);
      check_eq("misaligned_no_req", mem_req, 1'b0);
      check_eq("misaligned_stall", stall, 1'b0);
      @(negedge clk);
      check_eq("misaligned_end", misaligned, 1'b0);
      check_eq("misaligned_no_req2", mem_req, 1'b0);
      return;
    end
    acked = 1'b0;
    for (int k = 0; k < TO && !acked; k++) begin
      check_eq("acc_mem_req", mem_req, 1'b1);
      check_eq("acc_stall", stall, 1'b1);
      check_eq("acc_mem_addr", mem_addr, a & 32'hFFFF_FFFC);
      check_eq("acc_mem_we", mem_we, w);
      check_eq("acc_mem_be", mem_be, w ? model_be(sz, a) : 4'hF);
      if (w) check_eq("acc_mem_wdata", mem_wdata, model_wdata(sz, wd));
      check_eq("acc_no_pulse", {load_valid, misaligned, timeout_err}, 3'b000);
      if (k == delay) begin
        mem_ack = 1'b1; mem_rdata = rd;
      end
      @(negedge clk);
      mem_ack = 1'b0; mem_rdata = $urandom;
      if (k == delay) acked = 1'b1;
    end
    if (acked) begin
      mem_ack = 1'($urandom_range(0, 1));
      check_eq("resp_load_valid", load_valid, !w);
      if (!w) check_eq("resp_load_data", load_data, model_load(sz, a, rd, sg));
      check_eq("resp_no_timeout", timeout_err, 1'b0);
      check_eq("resp_mem_req", mem_req, 1'b0);
      check_eq("resp_stall", stall, 1'b0);
      @(negedge clk);
      mem_ack = 1'b0;
      check_eq("post_resp_pulse", load_valid, 1'b0);
      check_eq("post_resp_req", mem_req, 1'b0);
    end else begin
      check_eq("timeout_pulse", timeout_err, 1'b1);
      check_eq("timeout_req_low", mem_req, 1'b0);
      check_eq("timeout_stall", stall, 1'b0);
      check_eq("timeout_no_lv", load_valid, 1'b0);
      @(negedge clk);
      check_eq("timeout_end", timeout_err, 1'b0);
      check_eq("timeout_req_stays_low", mem_req, 1'b0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; mem_ack = 1'b0; mem_rdata = 32'd0;
    req_valid = 1'b1; req_write = 1'b0; req_addr = 32'd0; req_wdata = 32'd0;
    req_size = 2'd0; req_signed = 1'b0;
    #3;
    check_eq("rst_stall", stall, 1'b0);
    check_eq("rst_outputs", {mem_req, mem_we, load_valid, misaligned, timeout_err, mem_be}, 9'd0);
    check_eq("rst_load_data", load_data, 32'd0);
    check_eq("rst_mem_addr", mem_addr, 32'd0);
    check_eq("rst_mem_wdata", mem_wdata, 32'd0);
    req_valid = 1'b0;
    @(negedge clk);
    reset = 1'b0;

    // Signed byte load from the top lane, immediate ack
    run_txn(1'b0, 32'h103, 32'h0, 2'd2, 1'b1, 0, 32'h80FF_1234);
    // Halfword store to the upper half
    run_txn(1'b1, 32'h202, 32'h0000_ABCD, 2'd1, 1'b0, 1, 32'h0);
    // Misaligned word load
    run_txn(1'b0, 32'h005, 32'h0, 2'd0, 1'b0, 0, 32'h0);
    // Word load that never gets acked
    run_txn(1'b0, 32'h40, 32'h0, 2'd0, 1'b0, TO + 5, 32'h0);
    // Ack arriving on the last allowed cycle
    run_txn(1'b0, 32'h44, 32'h0, 2'd3, 1'b0, TO - 1, 32'h1357_9BDF);

    // Reset during the second wait cycle of an unsigned halfword load
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h12; req_size = 2'd1; req_signed = 1'b0;
    @(negedge clk);
    req_valid = 1'b0;
    check_eq("rst_mid_wait1_req", mem_req, 1'b1);
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check_eq("rst_mid_req_drop", mem_req, 1'b0);
    check_eq("rst_mid_stall", stall, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    mem_ack = 1'b1; mem_rdata = 32'hFFFF_FFFF;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      mem_ack = 1'b0;
      check_eq("rst_after_pulses", {load_valid, misaligned, timeout_err, mem_req}, 4'd0);
    end
    run_txn(1'b0, 32'h12, 32'h0, 2'd1, 1'b0, 2, 32'hBEEF_7777);

    for (int t = 0; t < 80; t++) begin
      int gap;
      gap = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) begin
        @(negedge clk);
        mem_ack = 1'($urandom_range(0, 1));
        mem_rdata = $urandom;
        #1 check_eq("idle_ack_ignored", {mem_req, stall, load_valid, timeout_err}, 4'd0);
      end
      mem_ack = 1'b0;
      run_txn(1'($urandom_range(0, 1)), $urandom, $urandom, 2'($urandom_range(0, 3)),
              1'($urandom_range(0, 1)), $urandom_range(0, TO + 1), $urandom);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/mem_access_ctrl.md
MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

Interface
REQ-001 Parameter: TIMEOUT_CYCLES, 15, max cycles in ACCESS awaiting mem_ack (1..255).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 req_valid  input  1  MEM stage holds a load/store this cycle.
REQ-005 req_write  input  1  1 store, 0 load.
REQ-006 req_addr  input  32  byte address.
REQ-007 req_wdata  input  32  store data, right-aligned.
REQ-008 req_size  input  2  0 word, 1 halfword, 2 byte, 3 word.
REQ-009 req_signed  input  1  sign-extend load result.
REQ-010 stall  output  1  freeze pipeline (combinational).
REQ-011 load_data  output  32  extracted/extended load result.
REQ-012 load_valid  output  1  one-cycle pulse, load_data valid.
REQ-013 misaligned  output  1  one-cycle pulse, request rejected.
REQ-014 timeout_err  output  1  one-cycle pulse, access abandoned.
REQ-015 mem_req / mem_we  output  1 / 1  memory request / write strobe.
REQ-016 mem_addr  output  32  {req_addr[31:2],2'b00}.
REQ-017 mem_wdata / mem_be  output  32 / 4  lane-replicated data / byte enables.
REQ-018 mem_rdata / mem_ack  input  32 / 1  read word / access-complete.

Function
REQ-019 FSM SHALL have states IDLE, ACCESS, RESP.
REQ-020 IDLE: req_valid and aligned -> latch request, go ACCESS; mem_req registered, asserted from next cycle.
REQ-021 Alignment: halfword needs addr[0]=0, word (size 0/3) needs addr[1:0]=0, byte always aligned.
REQ-022 Misaligned in IDLE: no memory access, misaligned pulses next cycle, stay IDLE, stall low.
REQ-023 ACCESS: mem_req, mem_we, mem_addr, mem_wdata, mem_be held stable until mem_ack or timeout.
REQ-024 mem_ack in ACCESS -> RESP; load: capture extracted mem_rdata into load_data.
REQ-025 RESP: exactly one cycle; load_valid=1 for loads only; stall low; next state IDLE; req_valid ignored in RESP.
REQ-026 stall SHALL equal (IDLE and req_valid and aligned) or ACCESS.
REQ-027 Minimum load latency: accept cycle N, mem_req at N+1, ack at N+1 gives load_valid at N+2.
REQ-028 Wait counter clears on entering ACCESS, increments each non-ack cycle; reaching TIMEOUT_CYCLES -> timeout_err pulse, IDLE, mem_req dropped.
REQ-029 mem_ack and timeout same cycle: ack wins.
REQ-030 mem_ack in IDLE or RESP SHALL be ignored.
REQ-031 Load extraction: byte = rdata lane addr[1:0]; half = lane addr[1]; word = whole; upper bits zero.
REQ-032 Store: byte be=4'b0001<<addr[1:0], data replicated x4; half be=4'b0011<<(2*addr[1]), data x2; word be=4'b1111.
REQ-033 Loads SHALL drive mem_we=0 and mem_be=4'b1111.

Reset
REQ-034 reset asserted: state IDLE, counter 0, every output 0 (stall combinational, thus 0), immediately irrespective of clk.
REQ-035 reset during ACCESS abandons access; mem_req drops same cycle; no pulses issued after release.

Configuration
REQ-036 LOAD_SIGN_EXT_EN defined: req_signed=1 sign-extends byte/half loads from bit 7/15; undefined: req_signed ignored, always zero-extend.

Verification
REQ-037 LB signed, addr 0x103, rdata 0x80FF_1234, ack immediate -> mem_addr 0x100, load_data 0xFFFF_FF80 (macro on) / 0x0000_0080 (off), load_valid at N+2.
REQ-038 SH addr 0x202, wdata 0x0000_ABCD -> mem_we=1, mem_be 4'b1100, mem_wdata 0xABCD_ABCD, no load_valid.
REQ-039 LW addr 0x005 -> misaligned pulse one cycle, mem_req never asserted, stall 0.
REQ-040 LW, ack withheld, TIMEOUT_CYCLES=4 -> stall high 4 ACCESS cycles, timeout_err pulse, mem_req low afterwards.
REQ-041 LHU addr 0x12, ack after 3 wait cycles, reset pulsed in 2nd wait cycle -> mem_req 0 immediately, no load_valid, next request accepted normally.
